seq_divider: RTL and testbench

//   Unsigned sequential restoring divider: 2N-bit dividend / N-bit divisor -> 2N-bit quotient, N-bit remainder.

---
 rtl/seq_divider.sv | 159 +++++++++++++++
 tb/tb_seq_divider.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Unsigned restoring divider: 2N-bit dividend / N-bit divisor -> 2N-bit quotient, N-bit remainder.
// One quotient bit per clock, MSB first. The start/done handshake matches the Booth multiplier's.
module seq_divider #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           n_reset,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           done,
  output logic           busy,
  output logic           div_by_zero
);

  localparam int CW = $clog2(2*N) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(2*N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_p;
  logic [N-1:0]   w_p_nxt;
  logic [2*N-1:0] r_q;
  logic [2*N-1:0] w_q_nxt;
  logic [N-1:0]   r_d;
  logic [N-1:0]   w_d_nxt;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_nxt;

  logic [2*N-1:0] r_quotient;
  logic [2*N-1:0] w_quotient_nxt;
  logic [N-1:0]   r_remainder;
  logic [N-1:0]   w_remainder_nxt;
  logic           r_done;
  logic           w_done_nxt;
  logic           r_busy;
  logic           r_dbz;
  logic           w_dbz_nxt;

  logic [N:0]     w_p_sh;
  logic [2*N-1:0] w_q_sh;
  logic [N:0]     w_t;
  logic [N-1:0]   w_p_step;
  logic [2*N-1:0] w_q_step;

  // One restoring step: shift {P,Q} left, trial-subtract the divisor, keep the result if non-negative.
  // P stays below the divisor, so it fits in N bits; only the shifted value needs the extra bit.
  always_comb begin
    w_p_sh = {r_p, r_q[2*N-1]};
    w_q_sh = {r_q[2*N-2:0], 1'b0};
    w_t    = w_p_sh - {1'b0, r_d};
    if (w_t[N] == 1'b0) begin
      w_p_step = w_t[N-1:0];
      w_q_step = {w_q_sh[2*N-1:1], 1'b1};
    end else begin
      w_p_step = w_p_sh[N-1:0];
      w_q_step = w_q_sh;
    end
  end

  // Next-state and next-datapath decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_p_nxt         = r_p;
    w_q_nxt         = r_q;
    w_d_nxt         = r_d;
    w_cnt_nxt       = r_cnt;
    w_quotient_nxt  = r_quotient;
    w_remainder_nxt = r_remainder;
    w_dbz_nxt       = r_dbz;
    w_done_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (divisor != {N{1'b0}}) begin
            w_p_nxt     = {N{1'b0}};
            w_q_nxt     = dividend;
            w_d_nxt     = divisor;
            w_cnt_nxt   = {CW{1'b0}};
            w_state_nxt = S_BUSY;
          end else begin
            w_quotient_nxt  = {(2*N){1'b1}};
            w_remainder_nxt = dividend[N-1:0];
            w_dbz_nxt       = 1'b1;
            w_done_nxt      = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        w_p_nxt = w_p_step;
        w_q_nxt = w_q_step;
        if (r_cnt == LAST_CNT) begin
          w_quotient_nxt  = w_q_step;
          w_remainder_nxt = w_p_step;
          w_dbz_nxt       = 1'b0;
          w_done_nxt      = 1'b1;
          w_cnt_nxt       = {CW{1'b0}};
          w_state_nxt     = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Working registers and registered outputs; busy mirrors the next state so it is high exactly in BUSY.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_p         <= {N{1'b0}};
      r_q         <= {(2*N){1'b0}};
      r_d         <= {N{1'b0}};
      r_cnt       <= {CW{1'b0}};
      r_quotient  <= {(2*N){1'b0}};
      r_remainder <= {N{1'b0}};
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      r_p         <= w_p_nxt;
      r_q         <= w_q_nxt;
      r_d         <= w_d_nxt;
      r_cnt       <= w_cnt_nxt;
      r_quotient  <= w_quotient_nxt;
      r_remainder <= w_remainder_nxt;
      r_done      <= w_done_nxt;
      r_busy      <= (w_state_nxt == S_BUSY);
      r_dbz       <= w_dbz_nxt;
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign done        = r_done;
  assign busy        = r_busy;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed table-driven bench for seq_divider at N=8, plus multi-cycle corner sequences and a random sweep.
module tb_seq_divider;

  localparam int N = 8;

  logic           clk;
  logic           n_reset;
  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;
  logic           done;
  logic           busy;
  logic           div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .done        (done),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dd;
    logic [7:0]  dv;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge. Returns in the done cycle (#1 after that edge), with start low.
  // k is the index of the sampled cycle after the start edge in which done appeared (1 = right after it).
  task automatic run_div(input logic [15:0] dd, input logic [7:0] dv, input bit hold,
                         output logic [15:0] q, output logic [7:0] r, output logic dbz,
                         output int k, output int busy_err);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(posedge clk); #1;
    if (hold) begin
      dividend = ~dd;
      divisor  = dv ^ 8'h5A;
    end else begin
      start = 1'b0;
    end
    k = 1;
    busy_err = 0;
    while (!done && k < 100) begin
      if (k >= 2 && !busy) busy_err++;
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    q   = quotient;
    r   = remainder;
    dbz = div_by_zero;
  endtask

  logic [15:0] q, mq;
  logic [7:0]  r, mr, rdv;
  logic [15:0] rdd;
  logic        dbz;
  int          k, berr, sel;

  initial begin
    vecs[0] = '{16'd1000,  8'd7,   16'd142,   8'd6,   1'b0, 17};
    vecs[1] = '{16'hFFFF,  8'h01,  16'hFFFF,  8'h00,  1'b0, 17};
    vecs[2] = '{16'hFFFF,  8'hFF,  16'h0101,  8'h00,  1'b0, 17};
    vecs[3] = '{16'h1234,  8'h00,  16'hFFFF,  8'h34,  1'b1, 1};
    vecs[4] = '{16'd5,     8'd200, 16'd0,     8'd5,   1'b0, 17};
    vecs[5] = '{16'd100,   8'd9,   16'd11,    8'd1,   1'b0, 17};
    vecs[6] = '{16'd0,     8'd5,   16'd0,     8'd0,   1'b0, 17};
    vecs[7] = '{16'h00FF,  8'h10,  16'h000F,  8'h0F,  1'b0, 17};
    vecs[8] = '{16'hFF00,  8'h80,  16'h01FE,  8'h00,  1'b0, 17};
    vecs[9] = '{16'hFFFF,  8'h02,  16'h7FFF,  8'h01,  1'b0, 17};

    n_reset  = 1'b0;
    start    = 1'b0;
    dividend = 16'h0000;
    divisor  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_quotient", 32'(quotient), 32'h0);
    chk("reset_remainder", 32'(remainder), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_dbz", 32'(div_by_zero), 32'h0);
    n_reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_div(vecs[i].dd, vecs[i].dv, 1'b0, q, r, dbz, k, berr);
      chk($sformatf("v%0d_quotient", i), 32'(q), 32'(vecs[i].q));
      chk($sformatf("v%0d_remainder", i), 32'(r), 32'(vecs[i].r));
      chk($sformatf("v%0d_dbz", i), 32'(dbz), 32'(vecs[i].dbz));
      chk($sformatf("v%0d_done_cycle", i), 32'(k), 32'(vecs[i].lat));
      chk($sformatf("v%0d_busy_before_done", i), 32'(berr), 32'h0);
      chk($sformatf("v%0d_busy_in_done", i), 32'(busy), 32'h0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'h0);
      chk($sformatf("v%0d_hold_quotient", i), 32'(quotient), 32'(vecs[i].q));
      chk($sformatf("v%0d_hold_remainder", i), 32'(remainder), 32'(vecs[i].r));
    end

    // start held high through BUSY with different operands
    run_div(16'd5, 8'd200, 1'b1, q, r, dbz, k, berr);
    chk("hold_quotient", 32'(q), 32'h0);
    chk("hold_remainder", 32'(r), 32'd5);
    chk("hold_done_cycle", 32'(k), 32'd17);
    @(posedge clk); #1;
    chk("hold_no_extra_done", 32'(done), 32'h0);
    chk("hold_idle", 32'(busy), 32'h0);

    // back-to-back: new start in the done cycle
    run_div(16'd1000, 8'd7, 1'b0, q, r, dbz, k, berr);
    chk("b2b_first_q", 32'(q), 32'd142);
    chk("b2b_first_r", 32'(r), 32'd6);
    dividend = 16'd100;
    divisor  = 8'd9;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_first_kept_q", 32'(quotient), 32'd142);
    chk("b2b_first_kept_r", 32'(remainder), 32'd6);
    chk("b2b_done_low", 32'(done), 32'h0);
    chk("b2b_busy", 32'(busy), 32'h1);
    k = 1;
    while (!done && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("b2b_second_done_cycle", 32'(k), 32'd17);
    chk("b2b_second_q", 32'(quotient), 32'd11);
    chk("b2b_second_r", 32'(remainder), 32'd1);

    // reset during iteration 5 aborts immediately
    dividend = 16'd1000;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_reset = 1'b0;
    #1;
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_quotient", 32'(quotient), 32'h0);
    chk("abort_remainder", 32'(remainder), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    n_reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_no_result", 32'(done), 32'h0);
    run_div(16'd1000, 8'd7, 1'b0, q, r, dbz, k, berr);
    chk("after_abort_q", 32'(q), 32'd142);
    chk("after_abort_r", 32'(r), 32'd6);
    chk("after_abort_done_cycle", 32'(k), 32'd17);
    @(posedge clk); #1;

    // random sweep against a reference model, biased toward divisor 0/1/max
    for (int i = 0; i < 1500; i++) begin
      rdd = 16'($urandom);
      sel = int'($urandom_range(0, 7));
      case (sel)
        0:       rdv = 8'h00;
        1:       rdv = 8'h01;
        2:       rdv = 8'hFF;
        default: rdv = 8'($urandom);
      endcase
      if (rdv == 8'h00) begin
        mq = 16'hFFFF;
        mr = rdd[7:0];
      end else begin
        mq = rdd / 16'(rdv);
        mr = 8'(rdd % 16'(rdv));
      end
      run_div(rdd, rdv, 1'b0, q, r, dbz, k, berr);
      chk($sformatf("rand%0d_q_%0h_%0h", i, rdd, rdv), 32'(q), 32'(mq));
      chk($sformatf("rand%0d_r_%0h_%0h", i, rdd, rdv), 32'(r), 32'(mr));
      chk($sformatf("rand%0d_dbz", i), 32'(dbz), 32'(rdv == 8'h00));
      if (rdv != 8'h00) begin
        chk($sformatf("rand%0d_identity", i), 32'(q) * 32'(rdv) + 32'(r), 32'(rdd));
        chk($sformatf("rand%0d_r_lt_d", i), 32'(r < rdv), 32'h1);
      end
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
